// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: round-robin sharing of the FPro MMIO bus between N_M masters.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   m_req/m_wr              per-master level request and write flag, held until ack
//   m_addr/m_wr_data        flattened per-master address and write data
//   m_ack                   one-cycle completion pulse to the served master
//   m_rd_data               registered read data, valid in the ack cycle
//   mmio_cs/wr/rd/addr/...  FPro bus towards the MMIO controller
//   mmio_rd_data            combinational read data from the slot
//   busy                    high while a transaction is on the bus or being acked
module mmio_bus_arbiter #(
   parameter int N_M = 2,
   parameter int AW  = 21
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_M-1:0]    m_req,
   input  logic [N_M-1:0]    m_wr,
   input  logic [N_M*AW-1:0] m_addr,
   input  logic [N_M*32-1:0] m_wr_data,
   output logic [N_M-1:0]    m_ack,
   output logic [31:0]       m_rd_data,
   output logic              mmio_cs,
   output logic              mmio_wr,
   output logic              mmio_rd,
   output logic [AW-1:0]     mmio_addr,
   output logic [31:0]       mmio_wr_data,
   input  logic [31:0]       mmio_rd_data,
   output logic              busy
);
   localparam int IW = $clog2(N_M);
   typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;
   state_t state, state_nx;
   logic [IW-1:0] last_grant, gnt_idx, winner, cand;
   logic any_req, wr_q;
   logic [AW-1:0] addr_v [N_M];
   logic [31:0] data_v [N_M];
   for (genvar g = 0; g < N_M; g++) begin : g_unpack
      assign addr_v[g] = m_addr[g*AW +: AW];
      assign data_v[g] = m_wr_data[g*32 +: 32];
   end
   // Search upward from the master after the last grant; first requester wins.
   always_comb begin
      winner = '0;
      cand = '0;
      any_req = 1'b0;
      for (int k = 1; k <= N_M; k++) begin
         cand = IW'((int'(last_grant) + k) % N_M);
         if (!any_req && m_req[cand]) begin
            any_req = 1'b1;
            winner = cand;
         end
      end
   end
   always_comb begin
      state_nx = (state == IDLE) ? (any_req ? BUS : IDLE) : (state == BUS) ? ACK : IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant   <= IW'(N_M - 1);
         gnt_idx      <= '0;
         wr_q         <= 1'b0;
         mmio_addr    <= '0;
         mmio_wr_data <= '0;
         m_rd_data    <= '0;
      end else begin
         if (state == IDLE && any_req) begin
            last_grant   <= winner;
            gnt_idx      <= winner;
            wr_q         <= m_wr[winner];
            mmio_addr    <= addr_v[winner];
            mmio_wr_data <= data_v[winner];
         end
         if (state == BUS && !wr_q) m_rd_data <= mmio_rd_data;
      end
   end
   // Strobes decode straight from state so an asynchronous reset drops them at once.
   assign mmio_cs = (state == BUS);
   assign mmio_wr = mmio_cs & wr_q;
   assign mmio_rd = mmio_cs & ~wr_q;
   assign busy    = (state != IDLE);
   assign m_ack   = (state == ACK) ? (N_M'(1) << gnt_idx) : '0;
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb_mmio_bus_arbiter: randomized and directed checks of mmio_bus_arbiter against a transaction-level model.
module tb_mmio_bus_arbiter;
   localparam int N = 3;
   localparam int AW = 21;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [N-1:0] m_req = '0, m_wr = '0, m_ack;
   logic [N*AW-1:0] m_addr = '0;
   logic [N*32-1:0] m_wr_data = '0;
   logic [31:0] m_rd_data, mmio_wr_data, mmio_rd_data;
   logic mmio_cs, mmio_wr, mmio_rd, busy;
   logic [AW-1:0] mmio_addr;
   logic rd_override = 1'b0;
   logic [31:0] salt = 32'h1234_0000;
   logic [31:0] exp_rd = '0;
   int lg = N - 1;
   int n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   assign mmio_rd_data = rd_override ? 32'hDEADBEEF : ({11'h2B5, mmio_addr} ^ salt);

   mmio_bus_arbiter #(.N_M(N), .AW(AW)) dut (
      .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
      .m_wr_data(m_wr_data), .m_ack(m_ack), .m_rd_data(m_rd_data),
      .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
      .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data), .busy(busy)
   );

   function automatic logic [31:0] slot_val(input logic [AW-1:0] a);
      return {11'h2B5, a} ^ salt;
   endfunction

   function automatic int rr_next(input int last, input logic [N-1:0] req);
      for (int k = 1; k <= N; k++)
         if (req[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input int i, input logic r, input logic w, input logic [AW-1:0] a, input logic [31:0] d);
      m_req[i] = r;
      m_wr[i] = w;
      m_addr[i*AW +: AW] = a;
      m_wr_data[i*32 +: 32] = d;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      m_req = '0;
      tick();
      tick();
      reset = 1'b1;
      lg = N - 1;
      exp_rd = '0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({mmio_cs, mmio_wr, mmio_rd, busy, m_ack, m_rd_data, mmio_addr, mmio_wr_data} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got cs=%b wr=%b rd=%b busy=%b ack=%b rd_data=%h addr=%h wd=%h, expected all zero",
                  mmio_cs, mmio_wr, mmio_rd, busy, m_ack, m_rd_data, mmio_addr, mmio_wr_data);
      end
      reset = 1'b1;
      drive(0, 1'b1, 1'b0, 21'h00040, 32'h0);
      tick();
      n_cmp++;
      if ({mmio_cs, mmio_rd, busy} !== 3'b111) begin
         n_bad++;
         $display("FAIL pre_abort_bus: got cs/rd/busy=%b expected 111", {mmio_cs, mmio_rd, busy});
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({mmio_cs, mmio_wr, mmio_rd, busy, m_ack} !== '0) begin
         n_bad++;
         $display("FAIL abort_immediate: got cs/wr/rd/busy=%b ack=%b expected zero", {mmio_cs, mmio_wr, mmio_rd, busy}, m_ack);
      end
      tick();
      tick();
      n_cmp++;
      if (m_ack !== '0) begin
         n_bad++;
         $display("FAIL abort_no_ack_in_reset: got ack=%b expected 000", m_ack);
      end
      m_req = '0;
      reset = 1'b1;
      lg = N - 1;
      tick();
      n_cmp++;
      if ({m_ack, busy} !== '0) begin
         n_bad++;
         $display("FAIL abort_no_ack_after: got ack=%b busy=%b expected 0", m_ack, busy);
      end
      drive(1, 1'b1, 1'b0, 21'h000C0, 32'h0);
      tick();
      n_cmp++;
      if ({mmio_cs, mmio_wr, mmio_rd, mmio_addr} !== {3'b101, 21'h000C0}) begin
         n_bad++;
         $display("FAIL t1_bus: got cs/wr/rd=%b addr=%h expected 101 addr=000c0", {mmio_cs, mmio_wr, mmio_rd}, mmio_addr);
      end
      tick();
      exp_rd = slot_val(21'h000C0);
      n_cmp++;
      if ({m_ack, m_rd_data, mmio_cs} !== {3'b010, exp_rd, 1'b0}) begin
         n_bad++;
         $display("FAIL t1_ack: got ack=%b rd_data=%h cs=%b expected ack=010 rd_data=%h cs=0", m_ack, m_rd_data, mmio_cs, exp_rd);
      end
      m_req = '0;
      lg = 1;
      tick();
      n_cmp++;
      if ({m_ack, busy} !== '0) begin
         n_bad++;
         $display("FAIL t1_idle: got ack=%b busy=%b expected 0", m_ack, busy);
      end
   endtask

   task automatic test_write();
      drive(0, 1'b1, 1'b1, 21'h00080, 32'h0000_00A5);
      tick();
      n_cmp++;
      if ({mmio_cs, mmio_wr, mmio_rd, busy, mmio_addr, mmio_wr_data} !== {4'b1101, 21'h00080, 32'h0000_00A5}) begin
         n_bad++;
         $display("FAIL wr_bus: got cs/wr/rd/busy=%b addr=%h wd=%h expected 1101 00080 000000a5",
                  {mmio_cs, mmio_wr, mmio_rd, busy}, mmio_addr, mmio_wr_data);
      end
      tick();
      n_cmp++;
      if ({m_ack, m_rd_data} !== {3'b001, exp_rd}) begin
         n_bad++;
         $display("FAIL wr_ack: got ack=%b rd_data=%h expected ack=001 rd_data=%h", m_ack, m_rd_data, exp_rd);
      end
      m_req = '0;
      lg = 0;
      tick();
      n_cmp++;
      if ({mmio_cs, mmio_addr, mmio_wr_data} !== {1'b0, 21'h00080, 32'h0000_00A5}) begin
         n_bad++;
         $display("FAIL wr_hold: got cs=%b addr=%h wd=%h expected cs=0 addr=00080 wd=000000a5", mmio_cs, mmio_addr, mmio_wr_data);
      end
   endtask

   task automatic test_alternate();
      int ord [4] = '{0, 1, 0, 1};
      do_reset();
      drive(0, 1'b1, 1'b0, 21'h00100, 32'h0);
      drive(1, 1'b1, 1'b0, 21'h00104, 32'h0);
      for (int t = 0; t < 4; t++) begin
         tick();
         n_cmp++;
         if ({mmio_cs, mmio_addr} !== {1'b1, 21'h00100 + AW'(4 * ord[t])}) begin
            n_bad++;
            $display("FAIL alt_bus[%0d]: got cs=%b addr=%h expected master %0d", t, mmio_cs, mmio_addr, ord[t]);
         end
         tick();
         exp_rd = slot_val(21'h00100 + AW'(4 * ord[t]));
         n_cmp++;
         if ({m_ack, m_rd_data} !== {3'b001 << ord[t], exp_rd}) begin
            n_bad++;
            $display("FAIL alt_ack[%0d]: got ack=%b rd_data=%h expected ack=%b rd_data=%h", t, m_ack, m_rd_data, 3'b001 << ord[t], exp_rd);
         end
         if (t == 3) m_req = '0;
         tick();
      end
      lg = 1;
   endtask

   task automatic test_rr3();
      int ord [4] = '{0, 1, 2, 0};
      do_reset();
      drive(0, 1'b1, 1'b1, 21'h00200, 32'hA0A0_0000);
      drive(2, 1'b1, 1'b1, 21'h00208, 32'hA2A2_0002);
      for (int t = 0; t < 4; t++) begin
         tick();
         n_cmp++;
         if ({mmio_cs, mmio_wr, mmio_addr} !== {2'b11, 21'h00200 + AW'(4 * ord[t])}) begin
            n_bad++;
            $display("FAIL rr3_bus[%0d]: got cs/wr=%b addr=%h expected master %0d", t, {mmio_cs, mmio_wr}, mmio_addr, ord[t]);
         end
         tick();
         n_cmp++;
         if (m_ack !== (3'b001 << ord[t])) begin
            n_bad++;
            $display("FAIL rr3_ack[%0d]: got ack=%b expected %b", t, m_ack, 3'b001 << ord[t]);
         end
         if (t == 0) drive(1, 1'b1, 1'b1, 21'h00204, 32'hA1A1_0001);
         if (t == 1) m_req[1] = 1'b0;
         if (t == 3) m_req = '0;
         tick();
      end
      lg = 0;
   endtask

   task automatic test_single();
      logic [11:0] cs_seen = '0, ack_seen = '0, other_ack = '0;
      drive(0, 1'b1, 1'b1, 21'h00300, 32'h5555_AAAA);
      for (int c = 0; c < 12; c++) begin
         tick();
         cs_seen[c] = mmio_cs;
         ack_seen[c] = m_ack[0];
         other_ack[c] = |m_ack[2:1];
         if (c == 10) m_req = '0;
      end
      n_cmp++;
      if ({cs_seen, ack_seen} !== {12'h249, 12'h492}) begin
         n_bad++;
         $display("FAIL single_rate: got cs=%b ack=%b expected cs=%b ack=%b", cs_seen, ack_seen, 12'h249, 12'h492);
      end
      n_cmp++;
      if ({other_ack, m_rd_data} !== {12'h0, exp_rd}) begin
         n_bad++;
         $display("FAIL single_other: got other_ack=%b rd_data=%h expected 0 rd_data=%h", other_ack, m_rd_data, exp_rd);
      end
      lg = 0;
   endtask

   task automatic test_rd_hold();
      rd_override = 1'b1;
      drive(2, 1'b1, 1'b0, 21'h001F0, 32'h0);
      tick();
      tick();
      exp_rd = 32'hDEADBEEF;
      n_cmp++;
      if ({m_ack, m_rd_data} !== {3'b100, exp_rd}) begin
         n_bad++;
         $display("FAIL hold_read: got ack=%b rd_data=%h expected ack=100 rd_data=deadbeef", m_ack, m_rd_data);
      end
      m_req = '0;
      rd_override = 1'b0;
      tick();
      drive(0, 1'b1, 1'b1, 21'h00084, 32'h0000_005A);
      tick();
      tick();
      n_cmp++;
      if ({m_ack, m_rd_data} !== {3'b001, exp_rd}) begin
         n_bad++;
         $display("FAIL hold_write_ack: got ack=%b rd_data=%h expected ack=001 rd_data=deadbeef", m_ack, m_rd_data);
      end
      m_req = '0;
      tick();
      n_cmp++;
      if (m_rd_data !== exp_rd) begin
         n_bad++;
         $display("FAIL hold_after: got rd_data=%h expected deadbeef", m_rd_data);
      end
      lg = 0;
   endtask

   task automatic test_random();
      int w;
      logic ew;
      logic [AW-1:0] ea;
      logic [31:0] ed;
      do_reset();
      for (int it = 0; it < 300; it++) begin
         n_cmp++;
         if ({mmio_cs, busy, m_ack} !== '0) begin
            n_bad++;
            $display("FAIL rnd_idle[%0d]: got cs=%b busy=%b ack=%b expected 0", it, mmio_cs, busy, m_ack);
         end
         if ($urandom_range(3) == 0) salt = $urandom;
         for (int i = 0; i < N; i++)
            if (!m_req[i]) drive(i, ($urandom_range(2) == 0), 1'($urandom), AW'($urandom), $urandom);
         if (m_req == '0) begin
            tick();
            continue;
         end
         w = rr_next(lg, m_req);
         ew = m_wr[w];
         ea = m_addr[w*AW +: AW];
         ed = m_wr_data[w*32 +: 32];
         tick();
         n_cmp++;
         if ({mmio_cs, mmio_wr, mmio_rd, busy, mmio_addr, mmio_wr_data} !== {1'b1, ew, ~ew, 1'b1, ea, ed}) begin
            n_bad++;
            $display("FAIL rnd_bus[%0d]: got cs/wr/rd/busy=%b addr=%h wd=%h expected %b addr=%h wd=%h (master %0d)",
                     it, {mmio_cs, mmio_wr, mmio_rd, busy}, mmio_addr, mmio_wr_data, {1'b1, ew, ~ew, 1'b1}, ea, ed, w);
         end
         if (!ew) exp_rd = slot_val(ea);
         tick();
         n_cmp++;
         if ({m_ack, mmio_cs, mmio_wr, mmio_rd, busy, m_rd_data} !== {3'b001 << w, 4'b0001, exp_rd}) begin
            n_bad++;
            $display("FAIL rnd_ack[%0d]: got ack=%b cs/wr/rd/busy=%b rd_data=%h expected ack=%b 0001 rd_data=%h",
                     it, m_ack, {mmio_cs, mmio_wr, mmio_rd, busy}, m_rd_data, 3'b001 << w, exp_rd);
         end
         lg = w;
         if ($urandom_range(1) == 0) m_req[w] = 1'b0;
         else drive(w, 1'b1, 1'($urandom), AW'($urandom), $urandom);
         tick();
      end
      m_req = '0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write();
      test_alternate();
      test_rr3();
      test_single();
      test_rd_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
